// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and default operand width for the ALU op sequencer
package alu_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives an external combinational ALU from cmd_*, holds operands SETTLE_CYCLES, returns captured result on rsp_*; ALU side is A/B/select out, result/carry/zflag in; busy and op_count report activity
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_A,
  input  logic [WIDTH-1:0]     cmd_B,
  input  logic [2:0]           cmd_select,
  input  logic                 cmd_chain,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [2:0]           select,
  input  logic [2*WIDTH-1:0]   result,
  input  logic                 carry,
  input  logic                 zflag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zflag,
  output logic [2:0]           rsp_select,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count
);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [WIDTH-1:0] last_result;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last_result <= '0;
      A <= '0;
      B <= '0;
      select <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_carry <= 1'b0;
      rsp_zflag <= 1'b0;
      rsp_select <= '0;
      op_count <= '0;
    end else if (state == IDLE && cmd_valid) begin
      A <= cmd_chain ? last_result : cmd_A;
      B <= cmd_B;
      select <= cmd_select;
      cnt <= 4'(SETTLE_CYCLES - 1);
      state <= DRIVE;
    end else if (state == DRIVE) begin
      if (cnt == 4'd0) begin
        rsp_result <= result;
        rsp_carry <= carry;
        rsp_zflag <= zflag;
        rsp_select <= select;
        last_result <= result[WIDTH-1:0];
        rsp_valid <= 1'b1;
        state <= RESP;
      end else
        cnt <= cnt - 4'd1;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      op_count <= op_count + 1'b1;
      state <= IDLE;
    end
endmodule
